pulse_sequencer: RTL and testbench

Programmable pulse-train controller that sequences the single-line pulse output used by the clock/pulse test benches. It replaces hard-coded `#delay` pulse shaping with a clocked FSM. A requester loads the high length, low length and repeat count, then issues `start`. The block drives `signal` for exactly that many high/low periods, counted in `clock` cycles, and then reports completion.

---
 rtl/pulse_seq_pkg.sv | 20 ++
 rtl/phase_timer.sv | 30 +++
 rtl/pulse_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pulse_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse sequencer: state encoding and default field width.
package pulse_seq_pkg;

  // Default width of the length, count and progress fields.
  localparam int unsigned DefaultW = 8;

  // State encoding.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StHigh = HIGH,
    StLow  = LOW,
    StDone = DONE
  } state_e;

endpackage

// File: rtl/phase_timer.sv
// Loadable W-bit down-counter timing one high or low phase. Loading a length of
// len stores len-1 (a length of 0 is clamped to 1); `zero` marks the last cycle.
module phase_timer
  import pulse_seq_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Load len-1 on phase entry, otherwise count down and rest at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= (value == '0) ? '0 : value - W'(1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Programmable pulse-train controller: drives `signal` high for high_len cycles and
// low for low_len cycles, count times, then strobes `done` for one cycle.
// Optional feature: define PULSE_SEQ_CONT_EN to make count=0 mean "run until stop".
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic [W-1:0] high_len,
  input  logic [W-1:0] low_len,
  input  logic [W-1:0] count,
  output logic         signal,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] pulses_sent
);

  state_e       state_q;
  logic [W-1:0] high_q;
  logic [W-1:0] low_q;
  logic [W-1:0] count_q;
  logic [W-1:0] pulses_q;
  logic         signal_q;
  logic         busy_q;
  logic         done_q;

  logic         timer_load;
  logic [W-1:0] timer_value;
  logic         timer_zero;

  logic         start_empty;
  logic         train_end;
  logic [W-1:0] pulses_inc;

`ifdef PULSE_SEQ_CONT_EN
  // count=0 runs until stop, so the termination compare only applies to non-zero counts.
  assign start_empty = 1'b0;
  assign train_end   = (count_q != '0) && (pulses_q == count_q);
`else
  assign start_empty = (count == '0);
  assign train_end   = (pulses_q == count_q);
`endif

  // Saturating increment; only reachable at the top in continuous mode.
  assign pulses_inc = (pulses_q == '1) ? pulses_q : pulses_q + W'(1);

  // Reload the phase timer whenever a HIGH or LOW phase is entered.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = high_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          timer_load  = 1'b1;
          timer_value = high_len;
        end
      end
      StHigh: begin
        if (!stop && timer_zero) begin
          timer_load  = 1'b1;
          timer_value = low_q;
        end
      end
      StLow: begin
        if (!stop && timer_zero && !train_end) begin
          timer_load  = 1'b1;
          timer_value = high_q;
        end
      end
      default: begin
        timer_load  = 1'b0;
        timer_value = high_q;
      end
    endcase
  end

  phase_timer #(
    .W(W)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .load (timer_load),
    .value(timer_value),
    .zero (timer_zero)
  );

  // Sequencing FSM with parameter latches, progress counter and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      high_q   <= '0;
      low_q    <= '0;
      count_q  <= '0;
      pulses_q <= '0;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // start wins over a simultaneous stop, which is ignored here.
          if (start) begin
            high_q   <= high_len;
            low_q    <= low_len;
            count_q  <= count;
            pulses_q <= '0;
            if (start_empty) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q  <= StHigh;
              signal_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
        end
        StHigh: begin
          if (stop) begin
            // A partial high phase is not counted.
            state_q  <= StDone;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else if (timer_zero) begin
            pulses_q <= pulses_inc;
            state_q  <= StLow;
            signal_q <= 1'b0;
          end
        end
        StLow: begin
          if (stop) begin
            state_q  <= StDone;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else if (timer_zero) begin
            if (train_end) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q  <= StHigh;
              signal_q <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign signal      = signal_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulses_sent = pulses_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer: each issued train pushes its expected outcome;
// a monitor records the busy-period waveform and checks it when `done` is seen.
module tb_pulse_sequencer;

  localparam int W = 8;
  localparam int MaxCnt = (1 << W) - 1;
`ifdef PULSE_SEQ_CONT_EN
  localparam bit Cont = 1'b1;
`else
  localparam bit Cont = 1'b0;
`endif

  logic         clock;
  logic         reset;
  logic         start;
  logic         stop;
  logic [W-1:0] high_len;
  logic [W-1:0] low_len;
  logic [W-1:0] count;
  logic         signal;
  logic         busy;
  logic         done;
  logic [W-1:0] pulses_sent;

  pulse_sequencer #(
    .W(W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .high_len   (high_len),
    .low_len    (low_len),
    .count      (count),
    .signal     (signal),
    .busy       (busy),
    .done       (done),
    .pulses_sent(pulses_sent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected outcome of one train: busy length k, final pulse count, clamped phase lengths.
  typedef struct {
    int k;
    int pulses;
    int hp;
    int lp;
  } exp_t;

  exp_t exp_q[$];
  bit   trace[$];
  int   checks = 0;
  int   errors = 0;
  int   idle_high = 0;
  bit   done_prev = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Reference model: pulse train as pure arithmetic over the clamped lengths.
  function automatic exp_t model(input int h, input int l, input int c, input int stopk);
    exp_t e;
    int p;
    e.hp = (h == 0) ? 1 : h;
    e.lp = (l == 0) ? 1 : l;
    p = e.hp + e.lp;
    if (c == 0 && !Cont) e.k = 0;
    else if (stopk > 0) e.k = stopk;
    else e.k = c * p;
    // A high phase counts once its last cycle completes before the terminating edge.
    e.pulses = (e.k > e.hp) ? (e.k - 1 - e.hp) / p + 1 : 0;
    if (e.pulses > MaxCnt) e.pulses = MaxCnt;
    return e;
  endfunction

  task automatic check_train();
    exp_t e;
    int bad;
    if (exp_q.size() == 0) begin
      chk("unexpected_done", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("busy_cycles", trace.size(), e.k);
      bad = 0;
      for (int i = 0; i < trace.size() && i < e.k; i++) begin
        if (trace[i] != (((i % (e.hp + e.lp)) < e.hp) ? 1'b1 : 1'b0)) bad++;
      end
      chk("signal_pattern_errs", bad, 0);
      chk("pulses_sent", int'(pulses_sent), e.pulses);
      chk("busy_at_done", int'(busy), 0);
    end
    trace.delete();
  endtask

  // Monitor: record signal while busy, check the train whenever done rises.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      trace.delete();
      done_prev = 1'b0;
    end else begin
      if (done_prev) chk("done_width", int'(done), 0);
      if (busy === 1'b1) trace.push_back(signal);
      else if (signal !== 1'b0) idle_high++;
      if (done === 1'b1 && !done_prev) check_train();
      done_prev = (done === 1'b1);
    end
  end

  task automatic randomize_params();
    high_len = W'($urandom);
    low_len  = W'($urandom);
    count    = W'($urandom);
  endtask

  // Issue one train from IDLE and wait (bounded) until it completes and FSM is idle again.
  task automatic run_train(input int h, input int l, input int c, input int stopk_in,
                           input bit stop_with_start, input bit glitch);
    exp_t e;
    int stopk;
    int cyc;
    int limit;
    bit seen;
    stopk = stopk_in;
    if (Cont && c == 0 && stopk == 0) stopk = $urandom_range(1, 30);
    e = model(h, l, c, stopk);
    exp_q.push_back(e);
    repeat ($urandom_range(0, 2)) @(negedge clock);
    high_len = W'(h);
    low_len  = W'(l);
    count    = W'(c);
    start    = 1'b1;
    stop     = stop_with_start;
    cyc   = 0;
    seen  = 1'b0;
    limit = e.k + 20;
    while (!seen && cyc < limit) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      stop  = 1'b0;
      randomize_params();
      if (glitch && e.k >= 3 && cyc == 2) start = 1'b1;
      if (stopk > 0 && cyc == stopk) stop = 1'b1;
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    stop  = 1'b0;
    if (!seen) begin
      errors++;
      $display("FAIL train_timeout: no done within %0d cycles (h=%0d l=%0d c=%0d)",
               limit, h, l, c);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    high_len = '0;
    low_len  = '0;
    count    = '0;
    repeat (3) @(negedge clock);
    chk("reset_signal", int'(signal), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_pulses", int'(pulses_sent), 0);
    reset = 1'b0;
    @(negedge clock);

    run_train(2, 3, 2, 0, 1'b0, 1'b0);
    run_train(0, 0, 3, 0, 1'b0, 1'b0);
    run_train(5, 5, 4, 12, 1'b0, 1'b0);
    run_train(7, 2, 0, 0, 1'b0, 1'b0);
    run_train(3, 2, 2, 0, 1'b1, 1'b0);
    run_train(4, 3, 2, 0, 1'b0, 1'b1);

    // Reset in the middle of a high phase: outputs clear at once and no done follows.
    @(negedge clock);
    high_len = 8'd4;
    low_len  = 8'd4;
    count    = 8'd3;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("pre_reset_signal", int'(signal), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_signal", int'(signal), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_done", int'(done), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    run_train(4, 4, 3, 0, 1'b0, 1'b0);

`ifdef PULSE_SEQ_CONT_EN
    run_train(1, 1, 0, 600, 1'b0, 1'b0);
`endif

    for (int t = 0; t < 40; t++) begin
      int h;
      int l;
      int c;
      int sk;
      h  = $urandom_range(0, 6);
      l  = $urandom_range(0, 6);
      c  = $urandom_range(0, 5);
      sk = 0;
      if (c != 0 && $urandom_range(0, 3) == 0) begin
        sk = $urandom_range(1, c * ((h == 0 ? 1 : h) + (l == 0 ? 1 : l)));
      end
      run_train(h, l, c, sk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clock);
    chk("pending_expectations", exp_q.size(), 0);
    chk("signal_high_while_idle", idle_high, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
